// File: rtl/demux_deser_if.sv
// Serial-in / parallel-out link bundle for demux_deser.
// The master side feeds bits and consumes words; the slave side is the deserializer.
interface demux_deser_if #(
  parameter int WIDTH = 8
);
  logic             sin;
  logic             sin_valid;
  logic             sync;
  logic             dout_ready;
  logic             clr_ovr;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             busy;
  logic             overrun;

  modport master (
    output sin, sin_valid, sync, dout_ready, clr_ovr,
    input  dout, dout_valid, busy, overrun
  );

  modport slave (
    input  sin, sin_valid, sync, dout_ready, clr_ovr,
    output dout, dout_valid, busy, overrun
  );
endinterface

// File: rtl/demux_deser.sv
// Receive end of a mux-based serial link: a bit counter demuxes each accepted
// bit into a fixed assembly slot, and full words are handed off via valid/ready.
module demux_deser #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  demux_deser_if.slave bus
);
  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RECV} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] asm_q, asm_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             overrun_q, overrun_d;

  logic             accept;
  logic             complete;
  logic             drop;
  logic [WIDTH-1:0] bit_sel;
  logic [WIDTH-1:0] asm_full;

  // 1-to-WIDTH demux: only the slot addressed by cnt takes the incoming bit.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_demux
      assign bit_sel[gi]  = (cnt_q == CW'(gi));
      assign asm_full[gi] = bit_sel[gi] ? bus.sin : asm_q[gi];
    end
  endgenerate

  assign accept = bus.sin_valid && !bus.sync;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    asm_d        = asm_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    complete     = 1'b0;
    drop         = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          asm_d   = asm_full;
          cnt_d   = cnt_q + CW'(1);
          state_d = RECV;
        end
      end
      RECV: begin
        if (bus.sync) begin
          cnt_d   = '0;
          asm_d   = '0;
          state_d = IDLE;
        end else if (accept) begin
          if (cnt_q == LAST) begin
            complete = 1'b1;
            cnt_d    = '0;
            asm_d    = '0;
            state_d  = IDLE;
          end else begin
            asm_d = asm_full;
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A finished word goes out unless an unconsumed word is still being held.
    if (complete) begin
      if (!dout_valid_q || bus.dout_ready) begin
        dout_d       = asm_full;
        dout_valid_d = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end else if (dout_valid_q && bus.dout_ready) begin
      dout_valid_d = 1'b0;
    end

    overrun_d = drop ? 1'b1 : (bus.clr_ovr ? 1'b0 : overrun_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      asm_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      asm_q        <= asm_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.busy       = (cnt_q != '0);
  assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_demux_deser.sv
// Table vectors, hand-written multi-cycle sequences and a randomized run against
// a queue-based word-assembly model for demux_deser at WIDTH=8.
module tb_demux_deser;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  demux_deser_if #(.WIDTH(W)) bus();

  demux_deser #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic         sin;
    logic         vld;
    logic         sync;
    logic         rdy;
    logic         clr;
    logic [W-1:0] e_dout;
    logic         e_valid;
    logic         e_busy;
    logic         e_ovr;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  // reference model state
  bit         m_bits[$];
  logic [W-1:0] m_dout;
  bit         m_valid;
  bit         m_ovr;

  task automatic chk(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(string tag, logic [W-1:0] d, logic v, logic b, logic o);
    chk({tag, ".dout"},       int'(bus.dout),       int'(d));
    chk({tag, ".dout_valid"}, int'(bus.dout_valid), int'(v));
    chk({tag, ".busy"},       int'(bus.busy),       int'(b));
    chk({tag, ".overrun"},    int'(bus.overrun),    int'(o));
  endtask

  task automatic set_in(logic s, logic v, logic sy, logic r, logic c);
    bus.sin        = s;
    bus.sin_valid  = v;
    bus.sync       = sy;
    bus.dout_ready = r;
    bus.clr_ovr    = c;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(logic s, logic v, logic sy, logic r, logic c,
                     logic [W-1:0] d, logic ev, logic eb, logic eo);
    vec_t t;
    t.sin = s; t.vld = v; t.sync = sy; t.rdy = r; t.clr = c;
    t.e_dout = d; t.e_valid = ev; t.e_busy = eb; t.e_ovr = eo;
    tbl.push_back(t);
  endtask

  // Model: collect accepted bits in a queue; WIDTH of them (LSB first) form a word.
  task automatic m_apply(logic s, logic v, logic sy, logic r, logic c);
    bit           done = 0;
    bit           set_ovr = 0;
    logic [W-1:0] word = '0;
    if (sy) begin
      m_bits.delete();
    end else if (v) begin
      m_bits.push_back(s);
      if (m_bits.size() == W) begin
        foreach (m_bits[i]) word[i] = m_bits[i];
        m_bits.delete();
        done = 1;
      end
    end
    if (done) begin
      if (!m_valid || r) begin
        m_dout  = word;
        m_valid = 1;
      end else begin
        set_ovr = 1;
      end
    end else if (m_valid && r) begin
      m_valid = 0;
    end
    if (set_ovr) m_ovr = 1;
    else if (c)  m_ovr = 0;
  endtask

  task automatic m_reset();
    m_bits.delete();
    m_dout  = '0;
    m_valid = 0;
    m_ovr   = 0;
  endtask

  initial begin
    logic [W-1:0] wa5, w3c, w12, w81;
    logic         r, c, s, v, sy;
    wa5 = 8'hA5; w3c = 8'h3C; w12 = 8'h12; w81 = 8'h81;

    // ---------------- table ----------------
    for (int i = 0; i < W; i++)
      add(wa5[i], 1, 0, 0, 0, (i == W-1) ? 8'hA5 : 8'h00, i == W-1, i != W-1, 0);
    for (int i = 0; i < W; i++)
      add(w3c[i], 1, 0, 0, 0, 8'hA5, 1, i != W-1, i == W-1);
    add(0, 0, 0, 0, 1, 8'hA5, 1, 0, 0);
    for (int i = 0; i < W; i++)
      add(w3c[i], 1, 0, i == W-1, 0, (i == W-1) ? 8'h3C : 8'hA5, 1, i != W-1, 0);
    add(0, 0, 0, 1, 0, 8'h3C, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      add(1, 1, 0, 0, 0, 8'h3C, 0, 1, 0);
    add(1, 1, 1, 0, 0, 8'h3C, 0, 0, 0);
    for (int i = 0; i < W; i++)
      add(1, 1, 0, 0, 0, (i == W-1) ? 8'hFF : 8'h3C, i == W-1, i != W-1, 0);
    for (int i = 0; i < W; i++)
      add(w12[i], 1, 0, 0, i == W-1, 8'hFF, 1, i != W-1, i == W-1);
    add(0, 0, 0, 0, 1, 8'hFF, 1, 0, 0);
    add(0, 1, 1, 1, 0, 8'hFF, 0, 0, 0);

    // ---------------- reset state ----------------
    set_in(0, 0, 0, 0, 0);
    step();
    step();
    check_all("reset", 8'h00, 0, 0, 0);
    $display("reset: dout=%h valid=%b busy=%b ovr=%b", bus.dout, bus.dout_valid, bus.busy, bus.overrun);
    rst_n = 1'b1;

    foreach (tbl[k]) begin
      set_in(tbl[k].sin, tbl[k].vld, tbl[k].sync, tbl[k].rdy, tbl[k].clr);
      step();
      $display("vec %0d sin=%b v=%b sync=%b rdy=%b clr=%b -> dout=%h valid=%b busy=%b ovr=%b",
               k, tbl[k].sin, tbl[k].vld, tbl[k].sync, tbl[k].rdy, tbl[k].clr,
               bus.dout, bus.dout_valid, bus.busy, bus.overrun);
      check_all($sformatf("tbl%0d", k), tbl[k].e_dout, tbl[k].e_valid, tbl[k].e_busy, tbl[k].e_ovr);
    end

    // ---------------- gap inside a word ----------------
    for (int i = 0; i < W; i++) begin
      if (i == 4) begin
        for (int g = 0; g < 3; g++) begin
          set_in(1, 0, 0, 0, 0);
          step();
          $display("gap %0d: busy=%b valid=%b", g, bus.busy, bus.dout_valid);
          check_all("gap", 8'hFF, 0, 1, 0);
        end
      end
      set_in(wa5[i], 1, 0, 0, 0);
      step();
      $display("gapword bit %0d: dout=%h valid=%b busy=%b", i, bus.dout, bus.dout_valid, bus.busy);
      if (i == W-1) check_all("gap_done", 8'hA5, 1, 0, 0);
      else          check_all("gap_bit", 8'hFF, 0, 1, 0);
    end

    // ---------------- async reset mid-word ----------------
    for (int i = 0; i < 4; i++) begin
      set_in(1, 1, 0, 0, 0);
      step();
    end
    check_all("pre_rst", 8'hA5, 1, 1, 0);
    #3;
    rst_n = 1'b0;
    #1;
    $display("async reset: dout=%h valid=%b busy=%b ovr=%b", bus.dout, bus.dout_valid, bus.busy, bus.overrun);
    check_all("async_rst", 8'h00, 0, 0, 0);
    set_in(1, 1, 0, 0, 0);
    step();
    check_all("rst_edge", 8'h00, 0, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < W; i++) begin
      set_in(w81[i], 1, 0, 0, 0);
      step();
      $display("post-reset bit %0d: dout=%h valid=%b busy=%b", i, bus.dout, bus.dout_valid, bus.busy);
      if (i == W-1) check_all("post_rst_done", 8'h81, 1, 0, 0);
      else          check_all("post_rst_bit", 8'h00, 0, 1, 0);
    end

    // ---------------- randomized against model ----------------
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0);
    step();
    rst_n = 1'b1;
    m_reset();
    for (int n = 0; n < 3000; n++) begin
      s  = 1'($urandom_range(0, 1));
      v  = ($urandom_range(0, 99) < 70);
      sy = ($urandom_range(0, 31) == 0);
      r  = ($urandom_range(0, 99) < 30);
      c  = ($urandom_range(0, 15) == 0);
      set_in(s, v, sy, r, c);
      step();
      m_apply(s, v, sy, r, c);
      if (v && !sy && m_bits.size() == 0)
        $display("rand %0d word end: dout=%h valid=%b ovr=%b", n, bus.dout, bus.dout_valid, bus.overrun);
      check_all($sformatf("rand%0d", n), m_dout, m_valid, m_bits.size() != 0, m_ovr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
